// File: rtl/io_input_port.sv
// Memory-mapped input port: synchronized, debounced input levels with sticky edge flags.
// Define IO_INPUT_DEBOUNCE_EN to build the debounce counters; otherwise LEVEL follows sync directly.
module io_input_port #(
  parameter int unsigned N_IN            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [N_IN-1:0] RAW_IN,
  input  logic [3:0]      IOAddr,
  input  logic            IOWriteEn,
  input  logic [31:0]     IOWriteData,
  output logic [31:0]     IOReadData,
  output logic            IRQ
);

  localparam logic [3:0] AddrLevel = 4'h4;
  localparam logic [3:0] AddrRise  = 4'h5;
  localparam logic [3:0] AddrFall  = 4'h6;
  localparam logic [3:0] AddrMask  = 4'h7;

  logic [N_IN-1:0] sync0_q, sync1_q;
  logic [N_IN-1:0] level_q, level_d;
  logic [N_IN-1:0] rise_q, rise_d;
  logic [N_IN-1:0] fall_q, fall_d;
  logic [N_IN-1:0] mask_q, mask_d;
  logic            irq_q, irq_d;

  logic [N_IN-1:0] wdata;
  logic [N_IN-1:0] rise_set, fall_set;
  logic            wr_rise, wr_fall, wr_mask;

  // Only the low N_IN bits of a write are meaningful.
  logic unused_wdata;
  if (N_IN < 32) begin : g_unused_wdata
    assign unused_wdata = ^IOWriteData[31:N_IN];
  end else begin : g_no_unused_wdata
    assign unused_wdata = 1'b0;
  end

  assign wdata = IOWriteData[N_IN-1:0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= RAW_IN;
      sync1_q <= sync0_q;
    end
  end

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q [N_IN];
  logic [CntW-1:0] cnt_d [N_IN];

  // Counter clears on agreement or on acceptance, so it can never exceed CntLast.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < int'(N_IN); i++) begin
      cnt_d[i] = '0;
      if (sync1_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          level_d[i] = sync1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_IN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  always_comb begin
    level_d = sync1_q;
  end
`endif

  always_comb begin
    wr_rise  = IOWriteEn && (IOAddr == AddrRise);
    wr_fall  = IOWriteEn && (IOAddr == AddrFall);
    wr_mask  = IOWriteEn && (IOAddr == AddrMask);
    rise_set = level_d & ~level_q;
    fall_set = ~level_d & level_q;
    // A set on the same edge as a W1C of that bit wins.
    rise_d   = (rise_q & ~(wr_rise ? wdata : '0)) | rise_set;
    fall_d   = (fall_q & ~(wr_fall ? wdata : '0)) | fall_set;
    mask_d   = wr_mask ? wdata : mask_q;
    irq_d    = |(rise_q & mask_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    IOReadData = '0;
    case (IOAddr)
      AddrLevel: IOReadData[N_IN-1:0] = level_q;
      AddrRise:  IOReadData[N_IN-1:0] = rise_q;
      AddrFall:  IOReadData[N_IN-1:0] = fall_q;
      AddrMask:  IOReadData[N_IN-1:0] = mask_q;
      default:   IOReadData = '0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_io_input_port.sv
// Scoreboard bench for io_input_port: stimulus queues expected reads, a monitor compares them.
module tb_io_input_port;

  localparam int unsigned NIn = 4;
  localparam int unsigned Dc  = 4;
`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int Lat    = 2 + Dc;
  localparam int Glitch = 0;
`else
  localparam int Lat    = 3;
  localparam int Glitch = 2;
`endif

  logic           clk;
  logic           rst_n;
  logic [NIn-1:0] raw_in;
  logic [3:0]     io_addr;
  logic           io_we;
  logic [31:0]    io_wdata;
  logic [31:0]    io_rdata;
  logic           irq;

  io_input_port #(
    .N_IN           (NIn),
    .DEBOUNCE_CYCLES(Dc)
  ) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .RAW_IN     (raw_in),
    .IOAddr     (io_addr),
    .IOWriteEn  (io_we),
    .IOWriteData(io_wdata),
    .IOReadData (io_rdata),
    .IRQ        (irq)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: read data is combinational, so compare shortly after the address is presented.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (io_rdata !== e.data) begin
        n_fail++;
        $display("FAIL %s addr=%h: IOReadData=%h expected %h", e.name, e.addr, io_rdata, e.data);
      end
      n_checks++;
      if (irq !== e.irq) begin
        n_fail++;
        $display("FAIL %s addr=%h: IRQ=%b expected %b", e.name, e.addr, irq, e.irq);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] a, input logic [31:0] d,
                     input logic q);
    exp_t e;
    io_addr = a;
    e.name = name;
    e.addr = a;
    e.data = d;
    e.irq  = q;
    exp_q.push_back(e);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    io_addr  = a;
    io_wdata = d;
    io_we    = 1'b1;
    tick(1);
    io_we    = 1'b0;
    io_wdata = '0;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    raw_in   = 4'hF;
    io_addr  = '0;
    io_we    = 1'b0;
    io_wdata = '0;
    #3;
    for (int a = 0; a < 16; a++) chk("reset_sweep", 4'(a), 32'h0, 1'b0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(Lat - 1);
    chk("por_level_early", 4'h4, 32'h0, 1'b0);
    chk("por_rise_early", 4'h5, 32'h0, 1'b0);
    tick(1);
    chk("por_level", 4'h4, 32'hF, 1'b0);
    chk("por_rise", 4'h5, 32'hF, 1'b0);
    chk("por_fall", 4'h6, 32'h0, 1'b0);

    raw_in = 4'h0;
    tick(Lat);
    chk("drop_level", 4'h4, 32'h0, 1'b0);
    chk("drop_fall", 4'h6, 32'hF, 1'b0);
    wr(4'h5, 32'hF);
    wr(4'h6, 32'hF);
    chk("w1c_rise_all", 4'h5, 32'h0, 1'b0);
    chk("w1c_fall_all", 4'h6, 32'h0, 1'b0);

    // Three-cycle pulse on bit 1
    raw_in = 4'h2;
    tick(3);
    raw_in = 4'h0;
    tick(Lat + 4);
    chk("glitch_level", 4'h4, 32'h0, 1'b0);
    chk("glitch_rise", 4'h5, 32'(Glitch), 1'b0);
    chk("glitch_fall", 4'h6, 32'(Glitch), 1'b0);
    wr(4'h5, 32'hF);
    wr(4'h6, 32'hF);

    raw_in = 4'h2;
    tick(Lat - 1);
    chk("hold_level_early", 4'h4, 32'h0, 1'b0);
    tick(1);
    chk("hold_level", 4'h4, 32'h2, 1'b0);
    chk("hold_rise", 4'h5, 32'h2, 1'b0);
    wr(4'h5, 32'hF);

    raw_in = 4'h3;
    tick(Lat);
    chk("b0_up_level", 4'h4, 32'h3, 1'b0);
    raw_in = 4'h2;
    tick(Lat);
    chk("b0_rise", 4'h5, 32'h1, 1'b0);
    chk("b0_fall", 4'h6, 32'h1, 1'b0);
    chk("b0_down_level", 4'h4, 32'h2, 1'b0);
    wr(4'h5, 32'h1);
    chk("w1c_rise_b0", 4'h5, 32'h0, 1'b0);
    chk("fall_kept", 4'h6, 32'h1, 1'b0);
    wr(4'h6, 32'hF);

    // W1C of RISE[2] lands on the same edge LEVEL[2] rises
    raw_in = 4'h6;
    tick(Lat - 1);
    wr(4'h5, 32'h4);
    chk("collision_rise", 4'h5, 32'h4, 1'b0);
    chk("collision_level", 4'h4, 32'h6, 1'b0);
    wr(4'h5, 32'hF);

    wr(4'h7, 32'h8);
    chk("mask_load", 4'h7, 32'h8, 1'b0);
    raw_in = 4'hE;
    tick(Lat);
    chk("irq_rise_set", 4'h5, 32'h8, 1'b0);
    tick(1);
    chk("irq_asserted", 4'h5, 32'h8, 1'b1);
    wr(4'h5, 32'h8);
    chk("irq_clear_write", 4'h5, 32'h0, 1'b1);
    tick(1);
    chk("irq_dropped", 4'h5, 32'h0, 1'b0);

    raw_in = 4'hF;
    tick(Lat);
    chk("masked_rise", 4'h5, 32'h1, 1'b0);
    tick(2);
    chk("masked_no_irq", 4'h5, 32'h1, 1'b0);

    wr(4'h4, 32'h0);
    chk("level_ro", 4'h4, 32'hF, 1'b0);
    wr(4'h3, 32'hFFFF_FFFF);
    chk("unmapped_read", 4'h3, 32'h0, 1'b0);
    chk("unmapped_no_mask", 4'h7, 32'h8, 1'b0);
    chk("unmapped_hi", 4'hC, 32'h0, 1'b0);
    wr(4'h7, 32'hFFFF_FFFF);
    chk("mask_width", 4'h7, 32'hF, 1'b0);
    tick(1);
    chk("mask_irq", 4'h7, 32'hF, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d pending expectations, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
